// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order IF->IS instruction buffer; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
package fetch_queue_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] npc;
      logic [31:0] pc;
   } IF_ID_PACKET;
endpackage

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  IF_ID_PACKET                  if_packet_in,
   output logic                         fq_ready,
   input  logic                         is_stall,
   input  logic                         squash,
   output IF_ID_PACKET                  if_id_packet_out,
   output logic [$clog2(DEPTH+1)-1:0]   fq_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   IF_ID_PACKET   mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          has_entry;
   logic          enq, deq, enq_wr, deq_head;

   always_comb begin
      fq_ready         = (count_q != CW'(DEPTH));
      has_entry        = (count_q != '0);
      if_id_packet_out = '0;
      if (has_entry) begin
         if_id_packet_out       = mem_q[head_q];
         if_id_packet_out.valid = 1'b1;
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (!squash) begin
         if_id_packet_out = if_packet_in;
      end
`endif
      enq      = if_packet_in.valid && fq_ready && !squash;
      deq      = if_id_packet_out.valid && !is_stall && !squash;
      deq_head = deq && has_entry;
`ifdef FETCH_QUEUE_BYPASS_EN
      // A packet consumed straight from the input never occupies an entry.
      enq_wr   = enq && !(deq && !has_entry);
`else
      enq_wr   = enq;
`endif
      head_d   = deq_head ? head_q + 1'b1 : head_q;
      tail_d   = enq_wr ? tail_q + 1'b1 : tail_q;
      count_d  = count_q;
      case ({enq_wr, deq_head})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset || squash) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i].valid <= 1'b0;
         end
      end else begin
         if (enq_wr) begin
            mem_q[tail_q] <= if_packet_in;
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign fq_count = count_q;
endmodule
